// File: rtl/hilo_pipe.sv
// hilo_pipe: EX/MEM and MEM/WB latches for the HI/LO write path, the
// architectural HI/LO register they commit into, and the holding register
// for the multi-cycle MADD/MSUB partial product while EX is stalled.
// The mem_* and wb_* buses feed the forwarding logic in ex, which applies
// mem > wb > arch priority; data bits travel regardless of the enable.
module hilo_pipe #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     ex_hi_i,
  input  logic [DATA_W-1:0]     ex_lo_i,
  input  logic                  ex_whilo_i,
  input  logic [2*DATA_W-1:0]   ex_hilo_temp_i,
  input  logic [1:0]            ex_cnt_i,
  input  logic [STALL_W-1:0]    stall_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     mem_hi_o,
  output logic [DATA_W-1:0]     mem_lo_o,
  output logic                  mem_whilo_o,
  output logic [DATA_W-1:0]     wb_hi_o,
  output logic [DATA_W-1:0]     wb_lo_o,
  output logic                  wb_whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic [2*DATA_W-1:0]   hilo_temp_o,
  output logic [1:0]            cnt_o
);

  // Stage control decoded from the stall vector: ex_stop/mem_stop/wb_stop
  // are the EX, MEM and WB stall bits.
  logic ex_stop;
  logic mem_stop;
  logic wb_stop;

  assign ex_stop  = stall_i[3];
  assign mem_stop = stall_i[4];
  assign wb_stop  = stall_i[5];

  // EX/MEM latch: a stalled EX with a free MEM sends a bubble forward and
  // parks the partial product so the multi-cycle op can resume next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_hi_o    <= '0;
      mem_lo_o    <= '0;
      mem_whilo_o <= 1'b0;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else if (flush_i) begin
      mem_hi_o    <= '0;
      mem_lo_o    <= '0;
      mem_whilo_o <= 1'b0;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end else if (ex_stop && !mem_stop) begin
      mem_hi_o    <= '0;
      mem_lo_o    <= '0;
      mem_whilo_o <= 1'b0;
      hilo_temp_o <= ex_hilo_temp_i;
      cnt_o       <= ex_cnt_i;
    end else if (!ex_stop) begin
      mem_hi_o    <= ex_hi_i;
      mem_lo_o    <= ex_lo_i;
      mem_whilo_o <= ex_whilo_i;
      hilo_temp_o <= '0;
      cnt_o       <= '0;
    end
  end

  // MEM/WB latch: same bubble/hold pattern one stage further down.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_hi_o    <= '0;
      wb_lo_o    <= '0;
      wb_whilo_o <= 1'b0;
    end else if (flush_i || (mem_stop && !wb_stop)) begin
      wb_hi_o    <= '0;
      wb_lo_o    <= '0;
      wb_whilo_o <= 1'b0;
    end else if (!mem_stop) begin
      wb_hi_o    <= mem_hi_o;
      wb_lo_o    <= mem_lo_o;
      wb_whilo_o <= mem_whilo_o;
    end
  end

  // Architectural HI/LO: whatever sits in WB with its enable set commits,
  // independent of stall and flush; a held WB just rewrites the same value.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else if (wb_whilo_o) begin
      hi_o <= wb_hi_o;
      lo_o <= wb_lo_o;
    end
  end

endmodule

// File: tb/tb_hilo_pipe.sv
// tb_hilo_pipe: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a stage-level reference model.
module tb_hilo_pipe;

  localparam int DATA_W  = 32;
  localparam int STALL_W = 6;

  logic                clk = 1'b0;
  logic                rst;
  logic [DATA_W-1:0]   ex_hi_i;
  logic [DATA_W-1:0]   ex_lo_i;
  logic                ex_whilo_i;
  logic [2*DATA_W-1:0] ex_hilo_temp_i;
  logic [1:0]          ex_cnt_i;
  logic [STALL_W-1:0]  stall_i;
  logic                flush_i;
  logic [DATA_W-1:0]   mem_hi_o, mem_lo_o, wb_hi_o, wb_lo_o, hi_o, lo_o;
  logic                mem_whilo_o, wb_whilo_o;
  logic [2*DATA_W-1:0] hilo_temp_o;
  logic [1:0]          cnt_o;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit check_en     = 1'b0;

  hilo_pipe #(.DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
    .clk(clk), .rst(rst),
    .ex_hi_i(ex_hi_i), .ex_lo_i(ex_lo_i), .ex_whilo_i(ex_whilo_i),
    .ex_hilo_temp_i(ex_hilo_temp_i), .ex_cnt_i(ex_cnt_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o), .mem_whilo_o(mem_whilo_o),
    .wb_hi_o(wb_hi_o), .wb_lo_o(wb_lo_o), .wb_whilo_o(wb_whilo_o),
    .hi_o(hi_o), .lo_o(lo_o),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: a HI/LO write "packet" per pipeline slot plus the
  // architectural pair and the parked multi-cycle state.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              w;
  } pkt_t;

  typedef struct packed {
    pkt_t                mem;
    pkt_t                wb;
    logic [DATA_W-1:0]   arch_hi;
    logic [DATA_W-1:0]   arch_lo;
    logic [2*DATA_W-1:0] temp;
    logic [1:0]          cnt;
  } model_t;

  model_t m = '0;

  // One clock of the pipeline expressed as packet movement between slots.
  function automatic model_t step(model_t s);
    model_t n;
    pkt_t   ex_pkt;
    pkt_t   bubble;
    bit     ex_stuck, mem_stuck, wb_stuck;
    n = s;
    bubble = '0;
    ex_pkt = '{hi: ex_hi_i, lo: ex_lo_i, w: ex_whilo_i};
    ex_stuck  = stall_i[3];
    mem_stuck = stall_i[4];
    wb_stuck  = stall_i[5];
    if (rst) return '0;
    if (s.wb.w) begin
      n.arch_hi = s.wb.hi;
      n.arch_lo = s.wb.lo;
    end
    if (flush_i) begin
      n.mem = bubble; n.wb = bubble; n.temp = '0; n.cnt = '0;
      return n;
    end
    if (!mem_stuck)        n.wb = s.mem;
    else if (!wb_stuck)    n.wb = bubble;
    if (!ex_stuck) begin
      n.mem = ex_pkt; n.temp = '0; n.cnt = '0;
    end else if (!mem_stuck) begin
      n.mem = bubble; n.temp = ex_hilo_temp_i; n.cnt = ex_cnt_i;
    end
    return n;
  endfunction

  // Advance the model on every active edge using the inputs the DUT sees.
  always @(posedge clk) m <= step(m);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Continuous comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("mem_hi", 64'(mem_hi_o), 64'(m.mem.hi));
      checkOutput("mem_lo", 64'(mem_lo_o), 64'(m.mem.lo));
      checkOutput("mem_whilo", 64'(mem_whilo_o), 64'(m.mem.w));
      checkOutput("wb_hi", 64'(wb_hi_o), 64'(m.wb.hi));
      checkOutput("wb_lo", 64'(wb_lo_o), 64'(m.wb.lo));
      checkOutput("wb_whilo", 64'(wb_whilo_o), 64'(m.wb.w));
      checkOutput("hi", 64'(hi_o), 64'(m.arch_hi));
      checkOutput("lo", 64'(lo_o), 64'(m.arch_lo));
      checkOutput("hilo_temp", hilo_temp_o, m.temp);
      checkOutput("cnt", 64'(cnt_o), 64'(m.cnt));
    end
  end

  // Drive one cycle of inputs at the falling edge; outputs visible on the
  // next return reflect the previous call's inputs.
  task automatic applyStimulus(input logic r, input logic [DATA_W-1:0] hi, input logic [DATA_W-1:0] lo,
                               input logic w, input logic [2*DATA_W-1:0] tmp, input logic [1:0] c,
                               input logic [STALL_W-1:0] st, input logic fl);
    @(negedge clk);
    rst = r; ex_hi_i = hi; ex_lo_i = lo; ex_whilo_i = w;
    ex_hilo_temp_i = tmp; ex_cnt_i = c; stall_i = st; flush_i = fl;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, 2'd0, '0, 1'b0);
  endtask

  task automatic write(input logic [DATA_W-1:0] hi);
    applyStimulus(1'b0, hi, ~hi, 1'b1, '0, 2'd0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; ex_hi_i = '0; ex_lo_i = '0; ex_whilo_i = 1'b0;
    ex_hilo_temp_i = '0; ex_cnt_i = '0; stall_i = '0; flush_i = 1'b0;

    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, $urandom, $urandom, 1'b1, {$urandom, $urandom}, 2'($urandom),
                    6'($urandom), 1'($urandom));
    idle();
    check_en = 1'b1;
    checkOutput("rst_hi", 64'(hi_o), 64'h0);
    checkOutput("rst_mem_whilo", 64'(mem_whilo_o), 64'h0);
    checkOutput("rst_temp", hilo_temp_o, 64'h0);
    idle(); idle();
    checkOutput("idle_hi", 64'(hi_o), 64'h0);
    checkOutput("idle_wb_whilo", 64'(wb_whilo_o), 64'h0);

    // Single write latency.
    write(32'h12345678);
    idle();
    checkOutput("lat_mem_hi", 64'(mem_hi_o), 64'h12345678);
    idle();
    checkOutput("lat_wb_hi", 64'(wb_hi_o), 64'h12345678);
    idle();
    checkOutput("lat_hi", 64'(hi_o), 64'h12345678);
    checkOutput("lat_lo", 64'(lo_o), 64'hEDCBA987);
    idle(); idle();
    checkOutput("hold_hi", 64'(hi_o), 64'h12345678);

    // Back-to-back writes.
    write(32'hAAAA0001);
    write(32'hBBBB0002);
    idle();
    checkOutput("b2b_mem_hi", 64'(mem_hi_o), 64'hBBBB0002);
    checkOutput("b2b_wb_hi", 64'(wb_hi_o), 64'hAAAA0001);
    idle();
    checkOutput("b2b_hi_A", 64'(hi_o), 64'hAAAA0001);
    idle();
    checkOutput("b2b_hi_B", 64'(hi_o), 64'hBBBB0002);

    // EX stall parks the partial product and emits a bubble.
    applyStimulus(1'b0, 32'h44, 32'h55, 1'b1, 64'h00000001_FFFFFFFF, 2'd1, 6'b001111, 1'b0);
    applyStimulus(1'b0, 32'h44, 32'h55, 1'b1, 64'h00000001_FFFFFFFF, 2'd1, 6'b000000, 1'b0);
    checkOutput("stall_mem_whilo", 64'(mem_whilo_o), 64'h0);
    checkOutput("stall_temp", hilo_temp_o, 64'h00000001_FFFFFFFF);
    checkOutput("stall_cnt", 64'(cnt_o), 64'd1);
    idle();
    checkOutput("resume_mem_hi", 64'(mem_hi_o), 64'h44);
    checkOutput("resume_mem_whilo", 64'(mem_whilo_o), 64'h1);
    checkOutput("resume_cnt", 64'(cnt_o), 64'd0);
    checkOutput("resume_temp", hilo_temp_o, 64'h0);

    // MEM stall holds the MEM latch and bubbles WB.
    write(32'hC0C0C0C0);
    applyStimulus(1'b0, 32'h99, 32'h98, 1'b1, '0, 2'd0, 6'b011111, 1'b0);
    idle();
    checkOutput("memstall_mem_hi", 64'(mem_hi_o), 64'hC0C0C0C0);
    checkOutput("memstall_mem_whilo", 64'(mem_whilo_o), 64'h1);
    checkOutput("memstall_wb_whilo", 64'(wb_whilo_o), 64'h0);
    idle(); idle(); idle();

    // Flush while D is in WB and E in MEM.
    write(32'hD0D0D0D0);
    write(32'hE0E0E0E0);
    applyStimulus(1'b0, 32'h77, 32'h66, 1'b1, 64'h1234, 2'd2, '0, 1'b1);
    checkOutput("preflush_wb_hi", 64'(wb_hi_o), 64'hD0D0D0D0);
    checkOutput("preflush_mem_hi", 64'(mem_hi_o), 64'hE0E0E0E0);
    idle();
    checkOutput("flush_mem_whilo", 64'(mem_whilo_o), 64'h0);
    checkOutput("flush_wb_whilo", 64'(wb_whilo_o), 64'h0);
    checkOutput("flush_mem_hi", 64'(mem_hi_o), 64'h0);
    checkOutput("flush_hi_D", 64'(hi_o), 64'hD0D0D0D0);
    idle(); idle();
    checkOutput("flush_E_dropped", 64'(hi_o), 64'hD0D0D0D0);

    // Random traffic with realistic stall patterns, flushes and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [STALL_W-1:0] st;
      case ($urandom_range(0, 7))
        0:       st = 6'b000111;
        1:       st = 6'b001111;
        2:       st = 6'b011111;
        3:       st = 6'b111111;
        4:       st = 6'($urandom);
        default: st = 6'b000000;
      endcase
      applyStimulus(($urandom_range(0, 99) == 0), $urandom, $urandom, 1'($urandom),
                    {$urandom, $urandom}, 2'($urandom), st, ($urandom_range(0, 15) == 0));
    end
    idle(); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
